// File: rtl/eccop_pkg.sv
// eccop_pkg: operand RAM default sizes, sizing helpers and clear FSM encoding
package eccop_pkg;
   localparam int ECCOP_OP_W  = 260;
   localparam int ECCOP_DEPTH = 64;
   typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_t;
   function automatic int lane_count(input int op_w, input int bus_w);
      return (op_w + bus_w - 1) / bus_w;
   endfunction
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/eccop_opram_lane.sv
// eccop_opram_lane: one DEPTH x W lane slice, single write port, two async read ports
module eccop_opram_lane #(
   parameter int W     = 32,
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr_a,
   output logic [W-1:0]  rdata_a,
   input  logic [AW-1:0] raddr_b,
   output logic [W-1:0]  rdata_b
);
   logic [W-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/eccop_opram_mp.sv
// eccop_opram_mp: lane-sliced operand RAM with bus port, masked op port and clear engine
module eccop_opram_mp
   import eccop_pkg::*;
#(
   parameter int OP_W       = ECCOP_OP_W,
   parameter int DEPTH      = ECCOP_DEPTH,
   parameter int BUS_W      = 32,
   parameter int RDW_FWD    = 1,
   parameter int CLR_ON_RST = 1,
   localparam int LANES     = lane_count(OP_W, BUS_W),
   localparam int LAW       = clog2_min1(LANES),
   localparam int AW        = clog2_min1(DEPTH),
   localparam int TOP_W     = OP_W - BUS_W * (LANES - 1)
) (
   input  logic              clk,
   input  logic              srst,
   input  logic [AW+LAW-1:0] bus_addr,
   input  logic [BUS_W-1:0]  bus_wdata,
   input  logic              bus_write,
   output logic              bus_wready,
   input  logic              bus_read,
   output logic [BUS_W-1:0]  bus_rdata,
   output logic              bus_rvalid,
   input  logic              op_read,
   input  logic [AW-1:0]     op_raddr,
   output logic [OP_W-1:0]   op_rdata,
   input  logic              op_write,
   input  logic [AW-1:0]     op_waddr,
   input  logic [LANES-1:0]  op_wmask,
   input  logic [OP_W-1:0]   op_wdata,
   input  logic              clr_start,
   output logic              clr_busy,
   output logic              err
);
   clr_state_t st, st_nx;
   logic [AW-1:0] clr_cnt, waddr, bus_word;
   logic [LAW-1:0] bus_lane;
   logic auto_clr, bus_commit, fwd_hit;
   logic [BUS_W-1:0] bus_q [LANES];
   logic [BUS_W-1:0] bus_sel;
   logic [OP_W-1:0] op_q;
   assign {bus_word, bus_lane} = bus_addr;
   assign clr_busy   = st == CLR_RUN;
   assign bus_commit = bus_write & ~op_write & ~clr_busy & ~bus_wready;
   assign waddr      = clr_busy ? clr_cnt : op_write ? op_waddr : bus_word;
   assign fwd_hit    = (RDW_FWD != 0) && op_write && !clr_busy && op_waddr == op_raddr;
   assign bus_sel    = ({1'b0, bus_lane} < (LAW+1)'(LANES)) ? bus_q[bus_lane] : '0;
   always_comb begin
      st_nx = st;
      st_nx = (st == CLR_IDLE) ? ((clr_start || auto_clr) ? CLR_RUN : CLR_IDLE)
                               : ((clr_cnt == AW'(DEPTH - 1)) ? CLR_IDLE : CLR_RUN);
   end
   always_ff @(posedge clk) begin
      if (srst) begin
         st         <= CLR_IDLE;
         clr_cnt    <= '0;
         auto_clr   <= CLR_ON_RST != 0;
         bus_wready <= 1'b0;
         bus_rvalid <= 1'b0;
         bus_rdata  <= '0;
         op_rdata   <= '0;
         err        <= 1'b0;
      end else begin
         st         <= st_nx;
         clr_cnt    <= clr_busy ? clr_cnt + 1'b1 : '0;
         auto_clr   <= 1'b0;
         bus_wready <= bus_commit;
         bus_rvalid <= bus_read;
         err        <= err | (op_write & clr_busy);
         if (bus_read) bus_rdata <= bus_sel;
         if (op_read) op_rdata <= op_q;
      end
   end
   // Top lane is narrower: bus writes drop the excess bits, bus reads zero-extend.
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      localparam int W = (k == LANES - 1) ? TOP_W : BUS_W;
      logic [W-1:0] ra, rb, wd;
      logic we;
      assign we = clr_busy | (op_write & op_wmask[k]) | (bus_commit & (bus_lane == LAW'(k)));
      assign wd = clr_busy ? '0 : op_write ? op_wdata[BUS_W*k +: W] : bus_wdata[W-1:0];
      eccop_opram_lane #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_lane (
         .clk     (clk),
         .we      (we),
         .waddr   (waddr),
         .wdata   (wd),
         .raddr_a (bus_word),
         .rdata_a (ra),
         .raddr_b (op_raddr),
         .rdata_b (rb)
      );
      assign bus_q[k] = BUS_W'(ra);
      assign op_q[BUS_W*k +: W] = (fwd_hit && op_wmask[k]) ? op_wdata[BUS_W*k +: W] : rb;
   end
endmodule
